// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared types and constants for the two-requester SRAM
//               arbiter: response FSM states, grant owner encoding, default
//               widths and one-hot grant bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Bit positions inside the one-hot grant vector produced by sram_arb_pick
  localparam int GNT_I = 0;
  localparam int GNT_D = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/sram_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pick
// Description : Grant selector for the fetch (inst) and load/store (data)
//               requesters. Produces a one-hot grant vector.
//               Macro SRAM_ARB_RR_EN: round-robin on ties using last owner;
//               otherwise fixed priority with data over inst.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic       inst_req,
  input  logic       data_req,
  input  owner_e     last_own,
  output logic [1:0] gnt_oh
);

  // Select at most one requester this cycle
  always_comb begin
    gnt_oh = 2'b00;
`ifdef SRAM_ARB_RR_EN
    if (inst_req && data_req) begin
      // On a tie the side that did not win last time goes first
      if (last_own == OWN_I) begin
        gnt_oh[GNT_D] = 1'b1;
      end else begin
        gnt_oh[GNT_I] = 1'b1;
      end
    end else begin
      gnt_oh[GNT_I] = inst_req;
      gnt_oh[GNT_D] = data_req;
    end
`else
    if (data_req) begin
      gnt_oh[GNT_D] = 1'b1;
    end else if (inst_req) begin
      gnt_oh[GNT_I] = 1'b1;
    end
`endif
  end

`ifndef SRAM_ARB_RR_EN
  // Fixed priority ignores history; keep the port for a uniform interface
  logic unused_last_own;
  assign unused_last_own = last_own;
`endif

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Arbitrates a fetch port and a load/store port onto one
//               single-ported SRAM. Grants are combinational in the request
//               cycle; the response comes exactly one cycle later.
//               Macro SRAM_ARB_RR_EN selects round-robin arbitration
//               (default build: fixed priority, data over inst).
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_gnt,
  output logic              inst_rvalid,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  state_e     state_q, state_d;
  logic       we_q, we_d;
  owner_e     last_own;
  logic [1:0] pick_oh;

  sram_arb_pick u_pick (
    .inst_req (inst_req),
    .data_req (data_req),
    .last_own (last_own),
    .gnt_oh   (pick_oh)
  );

  // Grants are combinational, so reset must gate them explicitly
  assign inst_gnt = resetn & pick_oh[GNT_I];
  assign data_gnt = resetn & pick_oh[GNT_D];

`ifdef SRAM_ARB_RR_EN
  owner_e last_q, last_d;

  // Remember who was granted most recently; unchanged on idle cycles
  always_comb begin
    last_d = last_q;
    if (inst_gnt) begin
      last_d = OWN_I;
    end else if (data_gnt) begin
      last_d = OWN_D;
    end
  end

  // Last-owner register, reset so the first tie goes to data
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_q <= OWN_I;
    end else begin
      last_q <= last_d;
    end
  end

  assign last_own = last_q;
`else
  assign last_own = OWN_I;
`endif

  // Steer the granted requester onto the SRAM port; all zero when idle
  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (data_gnt) begin
      sram_en    = 1'b1;
      sram_we    = data_we;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else if (inst_gnt) begin
      sram_en    = 1'b1;
      sram_addr  = inst_addr;
    end
  end

  // Next state follows this cycle's grant from any state; write flag captured at grant
  always_comb begin
    state_d = IDLE;
    we_d    = we_q;
    if (data_gnt) begin
      state_d = RESP_D;
      we_d    = data_we;
    end else if (inst_gnt) begin
      state_d = RESP_I;
    end
  end

  // Response FSM and captured write flag; reset drops any pending response
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
    end
  end

  // Return SRAM data to whichever requester owns the response cycle
  always_comb begin
    inst_rvalid = 1'b0;
    inst_rdata  = '0;
    data_rvalid = 1'b0;
    data_rdata  = '0;
    if (state_q == RESP_I) begin
      inst_rvalid = 1'b1;
      inst_rdata  = sram_rdata;
    end else if (state_q == RESP_D) begin
      data_rvalid = 1'b1;
      data_rdata  = we_q ? '0 : sram_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Self-checking bench for sram_arbiter. A behavioural SRAM
//               answers one cycle after sram_en; expected responses are
//               queued at grant time and compared one cycle later.
//               Honours SRAM_ARB_RR_EN for the contention expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = 32'h0;

  int n_chk  = 0;
  int n_pass = 0;

  // kind: 0 = no response, 1 = inst response, 2 = data response
  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] mem [logic [31:0]];

  sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_gnt    (inst_gnt),
    .inst_rvalid (inst_rvalid),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_gnt    (data_gnt),
    .data_rvalid (data_rvalid),
    .data_rdata  (data_rdata),
    .sram_en     (sram_en),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  // SRAM model: read data one cycle after sram_en; writes return all ones
  always @(posedge clk) begin
    if (sram_en && sram_we) mem[sram_addr] = sram_wdata;
    sram_rdata <= (sram_en && !sram_we) ? mem_rd(sram_addr) : 32'hFFFF_FFFF;
  end

  // Queue the response owed one cycle after a grant (g = {data, inst})
  task automatic push_exp(input logic [1:0] g, input logic [31:0] ia,
                          input logic [31:0] da, input logic dwe);
    exp_t e;
    if (g == 2'b01) begin
      e.kind = 2'd1; e.rdata = mem_rd(ia); exp_q.push_back(e);
    end else if (g == 2'b10) begin
      e.kind = 2'd2; e.rdata = dwe ? 32'h0 : mem_rd(da); exp_q.push_back(e);
    end
  endtask

  // Scoreboard: every cycle, responses must match what was queued last cycle
  always @(posedge clk) begin
    exp_t e;
    #3;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    n_chk++;
    if (inst_rvalid !== (e.kind == 2'd1) ||
        inst_rdata !== ((e.kind == 2'd1) ? e.rdata : 32'h0))
      $display("FAIL sb_inst @%0t: rvalid=%b rdata=%h, required rvalid=%b rdata=%h",
               $time, inst_rvalid, inst_rdata, (e.kind == 2'd1),
               (e.kind == 2'd1) ? e.rdata : 32'h0);
    else n_pass++;
    n_chk++;
    if (data_rvalid !== (e.kind == 2'd2) ||
        data_rdata !== ((e.kind == 2'd2) ? e.rdata : 32'h0))
      $display("FAIL sb_data @%0t: rvalid=%b rdata=%h, required rvalid=%b rdata=%h",
               $time, data_rvalid, data_rdata, (e.kind == 2'd2),
               (e.kind == 2'd2) ? e.rdata : 32'h0);
    else n_pass++;
  end

  task automatic idle_inputs();
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_we = 1'b0; data_addr = 32'h0; data_wdata = 32'h0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1234;
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h5678; data_wdata = 32'hCAFE;
    @(posedge clk); #3;
    n_chk++;
    if ({inst_gnt, data_gnt} !== 2'b00)
      $display("FAIL reset_gnt: got %b, required 00", {inst_gnt, data_gnt});
    else n_pass++;
    n_chk++;
    if ({sram_en, sram_we, sram_addr, sram_wdata} !== 66'h0)
      $display("FAIL reset_sram: en=%b we=%b addr=%h wdata=%h, required all 0",
               sram_en, sram_we, sram_addr, sram_wdata);
    else n_pass++;
    @(posedge clk); #1;
    idle_inputs();
    resetn = 1'b1;
    #3;
    n_chk++;
    if ({inst_gnt, data_gnt, sram_en} !== 3'b000)
      $display("FAIL idle_after_reset: gnt=%b en=%b, required 00/0",
               {inst_gnt, data_gnt}, sram_en);
    else n_pass++;
  endtask

  task automatic test_contention();
    logic [1:0] want [4];
`ifdef SRAM_ARB_RR_EN
    want = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
    want = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      inst_req = 1'b1; inst_addr = 32'h40 + 32'(4 * k);
      data_req = 1'b1; data_we = 1'b0; data_addr = 32'h200 + 32'(4 * k);
      #3;
      n_chk++;
      if ({data_gnt, inst_gnt} !== want[k])
        $display("FAIL contend_gnt[%0d]: {data,inst}=%b, required %b",
                 k, {data_gnt, inst_gnt}, want[k]);
      else n_pass++;
      n_chk++;
      if (sram_addr !== ((want[k] == 2'b10) ? data_addr : inst_addr))
        $display("FAIL contend_addr[%0d]: %h, required %h", k, sram_addr,
                 (want[k] == 2'b10) ? data_addr : inst_addr);
      else n_pass++;
      push_exp(want[k], inst_addr, data_addr, 1'b0);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_inst_read();
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'h1C00_0000;
    #3;
    n_chk++;
    if ({inst_gnt, data_gnt, sram_en, sram_we} !== 4'b1010)
      $display("FAIL ifetch_gnt: gnt_i=%b gnt_d=%b en=%b we=%b, required 1 0 1 0",
               inst_gnt, data_gnt, sram_en, sram_we);
    else n_pass++;
    n_chk++;
    if (sram_addr !== 32'h1C00_0000)
      $display("FAIL ifetch_addr: %h, required 1c000000", sram_addr);
    else n_pass++;
    push_exp(2'b01, inst_addr, 32'h0, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    #3;
    n_chk++;
    if (inst_rvalid !== 1'b1 || inst_rdata !== 32'h0280_0406)
      $display("FAIL ifetch_resp: rvalid=%b rdata=%h, required 1 02800406",
               inst_rvalid, inst_rdata);
    else n_pass++;
    n_chk++;
    if ({sram_en, sram_we, sram_addr, sram_wdata} !== 66'h0)
      $display("FAIL idle_bus: en=%b we=%b addr=%h wdata=%h, required all 0",
               sram_en, sram_we, sram_addr, sram_wdata);
    else n_pass++;
  endtask

  task automatic test_data_write();
    @(posedge clk); #1;
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h100; data_wdata = 32'hDEAD_BEEF;
    #3;
    n_chk++;
    if ({data_gnt, sram_en, sram_we} !== 3'b111 || sram_addr !== 32'h100 ||
        sram_wdata !== 32'hDEAD_BEEF)
      $display("FAIL store_bus: gnt=%b en=%b we=%b addr=%h wdata=%h, required 1 1 1 100 deadbeef",
               data_gnt, sram_en, sram_we, sram_addr, sram_wdata);
    else n_pass++;
    push_exp(2'b10, 32'h0, data_addr, 1'b1);
    @(posedge clk); #1;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h100; data_wdata = 32'h0;
    #3;
    n_chk++;
    if (data_rvalid !== 1'b1 || data_rdata !== 32'h0)
      $display("FAIL store_resp: rvalid=%b rdata=%h, required 1 00000000",
               data_rvalid, data_rdata);
    else n_pass++;
    // Read back the stored word; the scoreboard checks the returned data
    push_exp(2'b10, 32'h0, data_addr, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'h0;
    #3;
    push_exp({data_gnt, inst_gnt} == 2'b01 ? 2'b01 : 2'b01, inst_addr, 32'h0, 1'b0);
    n_chk++;
    if (inst_gnt !== 1'b1)
      $display("FAIL b2b_inst_gnt: %b, required 1", inst_gnt);
    else n_pass++;
    @(posedge clk); #1;
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h8;
    #3;
    n_chk++;
    if (inst_rvalid !== 1'b1 || data_gnt !== 1'b1 || sram_addr !== 32'h8)
      $display("FAIL b2b_overlap: inst_rvalid=%b data_gnt=%b addr=%h, required 1 1 8",
               inst_rvalid, data_gnt, sram_addr);
    else n_pass++;
    push_exp(2'b10, 32'h0, data_addr, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    #3;
    n_chk++;
    if (data_rvalid !== 1'b1 || inst_rvalid !== 1'b0)
      $display("FAIL b2b_data_resp: data_rvalid=%b inst_rvalid=%b, required 1 0",
               data_rvalid, inst_rvalid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h300;
    #3;
    push_exp(2'b10, 32'h0, data_addr, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b0;
    exp_q.delete();
    inst_req = 1'b1; inst_addr = 32'h44;
    #3;
    n_chk++;
    if ({inst_gnt, data_gnt, sram_en, sram_we, sram_addr, sram_wdata,
         inst_rvalid, inst_rdata, data_rvalid, data_rdata} !== '0)
      $display("FAIL midreset_outputs: gnt=%b en=%b rvalid=%b%b addr=%h, required all 0",
               {inst_gnt, data_gnt}, sram_en, inst_rvalid, data_rvalid, sram_addr);
    else n_pass++;
    // Release with a request already waiting: grant must appear at once
    @(posedge clk); #1;
    idle_inputs();
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h304; data_wdata = 32'h1111_2222;
    resetn = 1'b1;
    #3;
    n_chk++;
    if (data_rvalid !== 1'b0 || data_gnt !== 1'b1)
      $display("FAIL release: data_rvalid=%b data_gnt=%b, required 0 1",
               data_rvalid, data_gnt);
    else n_pass++;
    push_exp(2'b10, 32'h0, data_addr, 1'b1);
    @(posedge clk); #1;
    idle_inputs();
    repeat (2) @(posedge clk);
  endtask

  initial begin
    mem[32'h1C00_0000] = 32'h0280_0406;
    test_reset();
    test_contention();
    test_inst_read();
    test_data_write();
    test_back_to_back();
    test_reset_mid();
    #5;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning address width of requesters and SRAM port.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width of requesters and SRAM port.
REQ-003 The block SHALL have these ports, clock and reset first (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- inst_req  in  1  fetch requester, read request.
- inst_addr  in  ADDR_W  fetch address.
- inst_gnt  out  1  fetch request accepted this cycle.
- inst_rvalid  out  1  fetch read data valid.
- inst_rdata  out  DATA_W  fetch read data.
- data_req  in  1  load/store requester, request.
- data_we  in  1  1 = write, 0 = read.
- data_addr  in  ADDR_W  load/store address.
- data_wdata  in  DATA_W  store data.
- data_gnt  out  1  load/store request accepted this cycle.
- data_rvalid  out  1  load/store response; read data valid, or write complete.
- data_rdata  out  DATA_W  load read data.
- sram_en  out  1  shared SRAM access enable.
- sram_we  out  1  shared SRAM write enable.
- sram_addr  out  ADDR_W  shared SRAM address.
- sram_wdata  out  DATA_W  shared SRAM write data.
- sram_rdata  in  DATA_W  shared SRAM read data, valid one cycle after sram_en.

Function
REQ-004 The block SHALL grant at most one requester per cycle: inst_gnt and data_gnt are never both 1.
REQ-005 Grant SHALL be combinational in the request cycle: gnt = req of the selected requester, and sram_en/we/addr/wdata SHALL be driven from the granted requester in that same cycle.
REQ-006 With no grant, sram_en and sram_we SHALL be 0, and sram_addr and sram_wdata SHALL be 0.
REQ-007 A requester SHALL hold req and its payload until it sees gnt; the arbiter SHALL NOT depend on payload after the grant cycle.
REQ-008 The FSM SHALL have states IDLE, RESP_I, RESP_D, and the next state SHALL be RESP_I after an inst grant, RESP_D after a data grant, and IDLE otherwise, evaluated from every state.
REQ-009 In RESP_I, inst_rvalid SHALL be 1 and inst_rdata SHALL equal sram_rdata; otherwise inst_rvalid SHALL be 0 and inst_rdata SHALL be 0.
REQ-010 In RESP_D, data_rvalid SHALL be 1 for both reads and writes, and data_rdata SHALL equal sram_rdata for a read and 0 for a write; outside RESP_D, data_rvalid and data_rdata SHALL be 0.
REQ-011 Latency SHALL be exactly 1 cycle from grant to rvalid, and throughput SHALL be one grant per cycle, with a new grant allowed in the same cycle as the previous response.
REQ-012 The block SHALL register the write flag at grant, so that RESP_D knows whether to return sram_rdata or 0.
REQ-013 Default priority (macro absent) SHALL be fixed: data_req wins over inst_req when both are asserted.
REQ-014 Under fixed priority, the block SHALL NOT grant inst while data_req stays asserted; starvation in that case is permitted.

Reset
REQ-015 While resetn=0, all outputs SHALL be 0, including combinational grants, which are gated by reset.
REQ-016 Asserting resetn mid-transaction SHALL force state to IDLE, and the pending response SHALL be dropped with no rvalid after release.
REQ-017 After resetn rises, the first grant SHALL be possible in the first clk edge cycle that follows.

Configuration
REQ-018 Macro SRAM_ARB_RR_EN defined SHALL select round-robin arbitration using a last-grant register, reset value = inst.
REQ-019 With SRAM_ARB_RR_EN defined, on a simultaneous request the requester not granted last SHALL win, so the first tie after reset goes to data; a lone request SHALL always be granted.
REQ-020 With SRAM_ARB_RR_EN undefined, the last-grant register SHALL NOT exist and REQ-013 SHALL apply.

Structure
REQ-021 Package sram_arb_pkg SHALL hold the state enum (IDLE/RESP_I/RESP_D), the owner enum (OWN_I/OWN_D), and default width constants.
REQ-022 Sub-module sram_arb_pick SHALL hold the selector logic: inputs are the two requests plus last owner, and output is a one-hot grant.

Verification
REQ-023 The bench SHALL cover: inst_req=1, addr=0x1c000000, with SRAM returning 0x02800406 -> inst_gnt in cycle 0, and inst_rvalid=1 with rdata=0x02800406 in cycle 1.
REQ-024 The bench SHALL cover: data write, addr=0x100, wdata=0xdeadbeef -> sram_en=1, we=1, addr=0x100 in cycle 0, and data_rvalid=1 with data_rdata=0 in cycle 1.
REQ-025 The bench SHALL cover: both requests held for 4 cycles -> fixed priority gives data_gnt on all 4 cycles; RR gives data, inst, data, inst.
REQ-026 The bench SHALL cover: back-to-back reads inst@0x0 then data@0x8 in consecutive cycles -> the cycle-1 response inst_rvalid coincides with data_gnt, followed by data_rvalid in cycle 2.
REQ-027 The bench SHALL cover: resetn dropped in the RESP_D cycle -> all outputs 0 immediately, and no data_rvalid after release.
